// File: rtl/sdp_rr_arbiter_if.sv
// sdp_rr_arbiter_if: bundle of the requester handshake, the response return path and the
// simple-dual-port RAM ports around sdp_rr_arbiter.
//
// Signals
//   req        NREQ      per-requester request, held until granted
//   req_we     NREQ      1 = write, 0 = read
//   req_addr   NREQ*AW   packed addresses, requester i at [i*AW +: AW]
//   req_wdata  NREQ*DW   packed write data, requester i at [i*DW +: DW]
//   gnt        NREQ      combinational grant (accepted when req[i] & gnt[i])
//   rsp_valid  NREQ      one-hot read-response strobe
//   rsp_data   DW        shared read data, valid while rsp_valid != 0
//   ram_wen/ram_waddr/ram_din   registered RAM write port
//   ram_ren/ram_raddr           registered RAM read port
//   ram_dout   DW        RAM read data
//
// Modports
//   slave   the arbiter itself
//   master  everything around it: the client blocks and the RAM instance
interface sdp_rr_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 4,
  parameter int unsigned DW   = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               ram_wen;
  logic [AW-1:0]      ram_waddr;
  logic [DW-1:0]      ram_din;
  logic               ram_ren;
  logic [AW-1:0]      ram_raddr;
  logic [DW-1:0]      ram_dout;

  modport slave (
    input  req, req_we, req_addr, req_wdata, ram_dout,
    output gnt, rsp_valid, rsp_data,
    output ram_wen, ram_waddr, ram_din, ram_ren, ram_raddr
  );

  modport master (
    output req, req_we, req_addr, req_wdata, ram_dout,
    input  gnt, rsp_valid, rsp_data,
    input  ram_wen, ram_waddr, ram_din, ram_ren, ram_raddr
  );
endinterface

// File: rtl/sdp_rr_arbiter.sv
// sdp_rr_arbiter: shares one single-clock simple-dual-port RAM between NREQ requesters.
// Every cycle it grants at most one write and at most one read, each picked by its own
// round-robin pointer. The RAM ports are driven from registers, and each read result is
// routed back to its issuer through a one-hot tag pipeline matched to the RAM latency.
//
// Ports
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of sdp_rr_arbiter_if (requests, grants, responses, RAM ports)
//
// Parameters
//   NREQ    number of requesters (2..16)
//   AW, DW  RAM address / data width
//   RD_LAT  cycles from ram_ren sampled high to ram_dout valid; must match the RAM
module sdp_rr_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned AW     = 4,
  parameter int unsigned DW     = 2,
  parameter int unsigned RD_LAT = 2
) (
  input logic            clk,
  input logic            rst_n,
  sdp_rr_arbiter_if.slave bus
);

  localparam int unsigned PtrW    = $clog2(NREQ);
  localparam logic [PtrW:0] NreqExt = (PtrW + 1)'(NREQ);

  if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
    $error("sdp_rr_arbiter: NREQ must be in 2..16");
  end
  if (RD_LAT < 1) begin : g_bad_lat
    $error("sdp_rr_arbiter: RD_LAT must be at least 1");
  end

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(NREQ - 1)) ? '0 : p + PtrW'(1);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PtrW-1:0] i);
    return NREQ'(1) << i;
  endfunction

  // State
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic            ram_wen_q, ram_ren_q;
  logic [AW-1:0]   ram_waddr_q, ram_raddr_q;
  logic [DW-1:0]   ram_din_q;
  // Stage 0 runs alongside ram_ren; stages 1..RD_LAT follow the RAM read latency, so the
  // last stage lines up with ram_dout.
  logic [NREQ-1:0] tag_q [RD_LAT+1];

  // Unpacked view of the per-requester fields
  logic [AW-1:0] addr  [NREQ];
  logic [DW-1:0] wdata [NREQ];

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      addr[i]  = bus.req_addr[i*AW +: AW];
      wdata[i] = bus.req_wdata[i*DW +: DW];
    end
  end

  logic [NREQ-1:0] w_cand, r_cand;
  assign w_cand = bus.req & bus.req_we;
  assign r_cand = bus.req & ~bus.req_we;

  // Round-robin search: scan from the pointer, wrapping modulo NREQ, first hit wins.
  logic            w_found, r_found;
  logic [PtrW-1:0] w_idx, r_idx;
  logic [PtrW:0]   w_pos, r_pos;

  always_comb begin
    w_found = 1'b0;
    r_found = 1'b0;
    w_idx   = '0;
    r_idx   = '0;
    w_pos   = '0;
    r_pos   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_pos = {1'b0, wptr_q} + (PtrW + 1)'(k);
      if (w_pos >= NreqExt) w_pos = w_pos - NreqExt;
      r_pos = {1'b0, rptr_q} + (PtrW + 1)'(k);
      if (r_pos >= NreqExt) r_pos = r_pos - NreqExt;
      if (!w_found && w_cand[w_pos[PtrW-1:0]]) begin
        w_found = 1'b1;
        w_idx   = w_pos[PtrW-1:0];
      end
      if (!r_found && r_cand[r_pos[PtrW-1:0]]) begin
        r_found = 1'b1;
        r_idx   = r_pos[PtrW-1:0];
      end
    end
  end

  // A read hitting the address being written this cycle waits one cycle (rptr holds, so the
  // same reader wins next time) and thereby sees the new data.
  logic collide, r_grant;
  assign collide = w_found & r_found & (addr[w_idx] == addr[r_idx]);
  assign r_grant = r_found & ~collide;

  logic [NREQ-1:0] gnt_raw;
  always_comb begin
    gnt_raw = '0;
    if (w_found) gnt_raw = gnt_raw | onehot(w_idx);
    if (r_grant) gnt_raw = gnt_raw | onehot(r_idx);
  end

  assign bus.gnt = rst_n ? gnt_raw : '0;

  logic [PtrW-1:0] wptr_d, rptr_d;
  assign wptr_d = w_found ? ptr_inc(w_idx) : wptr_q;
  assign rptr_d = r_grant ? ptr_inc(r_idx) : rptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      ram_wen_q   <= 1'b0;
      ram_ren_q   <= 1'b0;
      ram_waddr_q <= '0;
      ram_raddr_q <= '0;
      ram_din_q   <= '0;
      for (int unsigned s = 0; s <= RD_LAT; s++) tag_q[s] <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ram_wen_q <= w_found;
      ram_ren_q <= r_grant;
      // Address/data hold their last value when idle
      if (w_found) begin
        ram_waddr_q <= addr[w_idx];
        ram_din_q   <= wdata[w_idx];
      end
      if (r_grant) ram_raddr_q <= addr[r_idx];
      tag_q[0] <= r_grant ? onehot(r_idx) : '0;
      for (int unsigned s = 1; s <= RD_LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign bus.ram_wen   = ram_wen_q;
  assign bus.ram_waddr = ram_waddr_q;
  assign bus.ram_din   = ram_din_q;
  assign bus.ram_ren   = ram_ren_q;
  assign bus.ram_raddr = ram_raddr_q;
  assign bus.rsp_valid = tag_q[RD_LAT];
  assign bus.rsp_data  = bus.ram_dout;

endmodule

// File: tb/tb_sdp_rr_arbiter.sv
module tb_sdp_rr_arbiter;
  localparam int unsigned NREQ   = 4;
  localparam int unsigned AW     = 4;
  localparam int unsigned DW     = 2;
  localparam int unsigned RD_LAT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sdp_rr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  sdp_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // RAM model: registered inputs, array read one cycle later into an output register.
  logic [DW-1:0] mem [2**AW];
  logic          wen_r, ren_r;
  logic [AW-1:0] waddr_r, raddr_r;
  logic [DW-1:0] din_r, dout_r;

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    wen_r = 1'b0; ren_r = 1'b0; waddr_r = '0; raddr_r = '0; din_r = '0; dout_r = '0;
  end

  always @(posedge clk) begin
    wen_r   <= bus.ram_wen;
    waddr_r <= bus.ram_waddr;
    din_r   <= bus.ram_din;
    if (wen_r) mem[waddr_r] <= din_r;
    ren_r   <= bus.ram_ren;
    raddr_r <= bus.ram_raddr;
    if (ren_r) dout_r <= mem[raddr_r];
  end

  assign bus.ram_dout = dout_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.req[i]               = 1'b1;
    bus.req_we[i]            = we;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    #1 rst_n = 1'b0;
    set_req(0, 1'b0, 4'd3, 2'd0);
    mid();
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_wen", 32'(bus.ram_wen), 0);
    chk("rst_ren", 32'(bus.ram_ren), 0);
    chk("rst_waddr", 32'(bus.ram_waddr), 0);
    chk("rst_raddr", 32'(bus.ram_raddr), 0);
    chk("rst_din", 32'(bus.ram_din), 0);
    chk("rst_rsp", 32'(bus.rsp_valid), 0);

    // Single write then read
    cyc(); rst_n = 1'b1; bus.req = '0; set_req(0, 1'b1, 4'd3, 2'd2);
    mid(); chk("s1_wgnt", 32'(bus.gnt), 32'h1);
    cyc(); bus.req = '0; set_req(0, 1'b0, 4'd3, 2'd0);
    mid(); chk("s1_rgnt", 32'(bus.gnt), 32'h1);
    chk("s1_wen", 32'(bus.ram_wen), 1);
    chk("s1_waddr", 32'(bus.ram_waddr), 3);
    chk("s1_din", 32'(bus.ram_din), 2);
    cyc(); bus.req = '0;
    mid(); chk("s1_ren", 32'(bus.ram_ren), 1);
    chk("s1_raddr", 32'(bus.ram_raddr), 3);
    chk("s1_wen_low", 32'(bus.ram_wen), 0);
    chk("s1_waddr_hold", 32'(bus.ram_waddr), 3);
    chk("s1_idle_gnt", 32'(bus.gnt), 0);
    cyc(); mid(); chk("s1_rsp_early", 32'(bus.rsp_valid), 0);
    cyc(); mid(); chk("s1_rsp", 32'(bus.rsp_valid), 32'h1);
    chk("s1_data", 32'(bus.rsp_data), 2);

    // Write round-robin (wptr = 1): addr 8+i <= i
    cyc(); for (int i = 0; i < 4; i++) set_req(i, 1'b1, AW'(8 + i), DW'(i));
    mid(); chk("s2_w0", 32'(bus.gnt), 32'h2);
    cyc(); bus.req[1] = 1'b0; mid(); chk("s2_w1", 32'(bus.gnt), 32'h4);
    cyc(); bus.req[2] = 1'b0; mid(); chk("s2_w2", 32'(bus.gnt), 32'h8);
    cyc(); bus.req[3] = 1'b0; mid(); chk("s2_w3", 32'(bus.gnt), 32'h1);
    cyc(); bus.req = '0; mid(); chk("s2_wlast", 32'(bus.ram_waddr), 8);
    cyc(); rst_n = 1'b0; mid(); chk("s2_rst_waddr", 32'(bus.ram_waddr), 0);
    cyc(); rst_n = 1'b1;

    // Read round-robin from rptr = 0, all four requesting continuously
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (k == 0) for (int i = 0; i < 4; i++) set_req(i, 1'b0, AW'(8 + i), 2'd0);
      mid();
      chk("s2_rgnt", 32'(bus.gnt), 32'h1 << (k % 4));
      if (k >= 3) begin
        chk("s2_rsp", 32'(bus.rsp_valid), 32'h1 << ((k - 3) % 4));
        chk("s2_data", 32'(bus.rsp_data), 32'((k - 3) % 4));
      end else begin
        chk("s2_rsp_none", 32'(bus.rsp_valid), 0);
      end
    end
    for (int k = 8; k < 11; k++) begin
      cyc();
      if (k == 8) bus.req = '0;
      mid();
      chk("s2_drain_gnt", 32'(bus.gnt), 0);
      chk("s2_drain_rsp", 32'(bus.rsp_valid), 32'h1 << ((k - 3) % 4));
      chk("s2_drain_data", 32'(bus.rsp_data), 32'((k - 3) % 4));
    end

    // Concurrent write (req1) and read (req2)
    cyc(); set_req(1, 1'b1, 4'd5, 2'd3); set_req(2, 1'b0, 4'd6, 2'd0);
    mid(); chk("s3_gnt", 32'(bus.gnt), 32'h6);
    cyc(); bus.req = '0;
    mid(); chk("s3_wen", 32'(bus.ram_wen), 1);
    chk("s3_ren", 32'(bus.ram_ren), 1);
    chk("s3_waddr", 32'(bus.ram_waddr), 5);
    chk("s3_raddr", 32'(bus.ram_raddr), 6);
    chk("s3_din", 32'(bus.ram_din), 3);
    cyc(); mid(); chk("s3_rsp_early", 32'(bus.rsp_valid), 0);
    cyc(); mid(); chk("s3_rsp", 32'(bus.rsp_valid), 32'h4);
    chk("s3_data", 32'(bus.rsp_data), 0);

    // Collision: req0 writes 7 <= 1 while req1 reads 7
    cyc(); set_req(0, 1'b1, 4'd7, 2'd1); set_req(1, 1'b0, 4'd7, 2'd0);
    mid(); chk("s4_gnt_t", 32'(bus.gnt), 32'h1);
    cyc(); bus.req[0] = 1'b0;
    mid(); chk("s4_gnt_t1", 32'(bus.gnt), 32'h2);
    cyc(); bus.req = '0;
    mid(); chk("s4_raddr", 32'(bus.ram_raddr), 7);
    cyc(); mid(); chk("s4_rsp_early", 32'(bus.rsp_valid), 0);
    cyc(); mid(); chk("s4_rsp", 32'(bus.rsp_valid), 32'h2);
    chk("s4_data", 32'(bus.rsp_data), 1);

    // Pointer wrap and hold (rptr = 2 here)
    cyc(); set_req(2, 1'b0, 4'd0, 2'd0);
    mid(); chk("s5_gnt2", 32'(bus.gnt), 32'h4);
    cyc(); bus.req = '0; set_req(0, 1'b0, 4'd3, 2'd0);
    mid(); chk("s5_rptr3", 32'(dut.rptr_q), 3);
    chk("s5_gnt0", 32'(bus.gnt), 32'h1);
    for (int j = 2; j < 7; j++) begin
      cyc();
      if (j == 2) bus.req = '0;
      mid();
      chk("s5_idle_gnt", 32'(bus.gnt), 0);
      chk("s5_rptr1", 32'(dut.rptr_q), 1);
      if (j == 3) begin
        chk("s5_rsp2", 32'(bus.rsp_valid), 32'h4);
        chk("s5_data2", 32'(bus.rsp_data), 0);
      end else if (j == 4) begin
        chk("s5_rsp0", 32'(bus.rsp_valid), 32'h1);
        chk("s5_data0", 32'(bus.rsp_data), 2);
      end else begin
        chk("s5_rsp_none", 32'(bus.rsp_valid), 0);
      end
    end

    // Reset with a read in flight
    cyc(); set_req(3, 1'b0, 4'd3, 2'd0);
    mid(); chk("s6_gnt", 32'(bus.gnt), 32'h8);
    cyc(); bus.req = '0; set_req(0, 1'b0, 4'd9, 2'd0); rst_n = 1'b0;
    mid(); chk("s6_ren", 32'(bus.ram_ren), 0);
    chk("s6_raddr", 32'(bus.ram_raddr), 0);
    chk("s6_waddr", 32'(bus.ram_waddr), 0);
    chk("s6_din", 32'(bus.ram_din), 0);
    chk("s6_gnt_rst", 32'(bus.gnt), 0);
    chk("s6_rsp_rst", 32'(bus.rsp_valid), 0);
    chk("s6_rptr", 32'(dut.rptr_q), 0);
    cyc(); mid(); chk("s6_gnt_rst2", 32'(bus.gnt), 0);
    chk("s6_rsp_rst2", 32'(bus.rsp_valid), 0);
    cyc(); rst_n = 1'b1; bus.req = '0;
    for (int j = 0; j < 4; j++) begin
      mid(); chk("s6_rsp_dropped", 32'(bus.rsp_valid), 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
